// File: rtl/debounce_switch.sv
// Switch debouncer: two-flop synchronizer feeding a symmetric persistence filter.
// Optional one-cycle o_Rise/o_Fall pulses are built when DEBOUNCE_EDGE_EN is defined.
`timescale 1ns/1ps
module debounce_switch #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_reset,
    input  logic i_Switch,
`ifdef DEBOUNCE_EDGE_EN
    output logic o_Rise,
    output logic o_Fall,
`endif
    output logic o_Switch
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sw_q;
    logic             sw_d;

    // meta_q may go metastable; only sync_q is ever consumed by the filter
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_Switch;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sw_d  = sw_q;
        if (sync_q == sw_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            sw_d  = sync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
            sw_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sw_q  <= sw_d;
        end
    end

    assign o_Switch = sw_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Registered from sw_d so the pulse lands in the same cycle o_Switch changes
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= sw_d & ~sw_q;
            fall_q <= ~sw_d & sw_q;
        end
    end

    assign o_Rise = rise_q;
    assign o_Fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_switch.sv
// Self-checking bench for debounce_switch (DEBOUNCE_LIMIT=4): window-based reference model
// compared every cycle, plus directed latency/glitch/reset scenarios with literal expectations.
`timescale 1ns/1ps
module tb_debounce_switch;

    localparam int DL = 4;

    logic i_Clk = 1'b0;
    logic rst;
    logic sw;
    logic o_Switch;
`ifdef DEBOUNCE_EDGE_EN
    logic o_Rise;
    logic o_Fall;
`endif

    int tests = 0;
    int fails = 0;

    debounce_switch #(.DEBOUNCE_LIMIT(DL)) dut (
        .i_Clk   (i_Clk),
        .i_reset (rst),
        .i_Switch(sw),
`ifdef DEBOUNCE_EDGE_EN
        .o_Rise  (o_Rise),
        .o_Fall  (o_Fall),
`endif
        .o_Switch(o_Switch)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference: output flips when the DL most recent filter inputs (raw samples
    // delayed two edges by the synchronizer) all disagree with the current output.
    logic m_sw   = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    logic hist[$];

    initial begin
        for (int k = 0; k < DL + 1; k++) hist.push_back(1'b0);
        forever begin
            @(posedge i_Clk or posedge rst);
            if (rst) begin
                m_sw = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
                hist.delete();
                for (int k = 0; k < DL + 1; k++) hist.push_back(1'b0);
            end else begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DL; k++)
                    if (hist[k] == m_sw) all_diff = 1'b0;
                m_rise = 1'b0;
                m_fall = 1'b0;
                if (all_diff) begin
                    m_sw   = ~m_sw;
                    m_rise = m_sw;
                    m_fall = ~m_sw;
                end
                hist.push_back(sw);
                void'(hist.pop_front());
            end
        end
    end

    always @(negedge i_Clk) begin
        tests++;
        if (o_Switch !== m_sw) begin
            fails++;
            $display("FAIL model_o_Switch t=%0t actual=%b required=%b", $time, o_Switch, m_sw);
        end
`ifdef DEBOUNCE_EDGE_EN
        tests++;
        if (o_Rise !== m_rise || o_Fall !== m_fall) begin
            fails++;
            $display("FAIL model_edges t=%0t actual rise/fall=%b%b required=%b%b",
                     $time, o_Rise, o_Fall, m_rise, m_fall);
        end
`endif
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // Drives one sample per cycle (last bit repeats past len), reports the edge
    // index at which o_Switch first equals target (0 = never) and pulse count.
    task automatic run_pattern(input string nm, input logic [31:0] pat, input int len,
                               input logic target, input int exp_edge,
                               input int exp_pulses, input int n_iter);
        int first;
        int pulses;
        first  = 0;
        pulses = 0;
        for (int i = 0; i < n_iter; i++) begin
            @(negedge i_Clk);
            sw = (i < len) ? pat[i] : pat[len-1];
            @(posedge i_Clk);
            #1;
            if (first == 0 && o_Switch == target) begin
                first = i + 1;
`ifdef DEBOUNCE_EDGE_EN
                check({nm, "_pulse_coincident"}, int'(target ? o_Rise : o_Fall), 1);
                check({nm, "_no_opposite_pulse"}, int'(target ? o_Fall : o_Rise), 0);
`endif
            end
`ifdef DEBOUNCE_EDGE_EN
            pulses += int'(target ? o_Rise : o_Fall);
`endif
        end
        check({nm, "_edge"}, first, exp_edge);
`ifdef DEBOUNCE_EDGE_EN
        check({nm, "_pulses"}, pulses, exp_pulses);
`else
        if (exp_pulses < 0) $display("note: negative pulse count requested");
`endif
    endtask

    initial begin
        rst = 1'b1;
        sw  = 1'b1;
        repeat (3) begin
            @(negedge i_Clk);
            check("reset_hold", int'(o_Switch), 0);
        end
        @(posedge i_Clk);
        #2 rst = 1'b0;
        sw = 1'b0;
        repeat (4) @(negedge i_Clk);

        run_pattern("step_rise",    32'hFFFF_FFFF, 1, 1'b1, 6,  1, 10);
        run_pattern("glitch_low3",  32'b1000,      4, 1'b0, 0,  0, 12);
        run_pattern("glitch_3_1_3", 32'b1000_1000, 8, 1'b0, 0,  0, 14);
        check("after_glitches", int'(o_Switch), 1);
        run_pattern("step_fall",    32'h0,         1, 1'b0, 6,  1, 10);
        run_pattern("bounce_rise",  32'b1_1110_1101, 9, 1'b1, 11, 1, 16);

        // Asynchronous reset with switch held high, asserted away from any edge
        @(posedge i_Clk);
        #2 rst = 1'b1;
        #1 check("async_reset", int'(o_Switch), 0);
        repeat (3) begin
            @(negedge i_Clk);
            check("reset_held_sw1", int'(o_Switch), 0);
        end
        @(posedge i_Clk);
        #2 rst = 1'b0;
        run_pattern("post_reset_rise", 32'hFFFF_FFFF, 1, 1'b1, 6, 1, 10);

        // Reset mid-count: three differing sync samples accumulated, then reset
        @(negedge i_Clk);
        sw = 1'b0;
        repeat (5) @(posedge i_Clk);
        #1 check("pre_reset_count3", int'(o_Switch), 1);
        #1 rst = 1'b1;
        #1 check("mid_count_reset", int'(o_Switch), 0);
        @(posedge i_Clk);
        #2 rst = 1'b0;
        run_pattern("after_reset_low", 32'h0, 1, 1'b1, 0, 0, 8);
        run_pattern("full_count_after_reset", 32'hFFFF_FFFF, 1, 1'b1, 6, 1, 10);

        repeat (2) @(negedge i_Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog t=%0t actual=timeout required=completion", $time);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/debounce_switch.md
DEBOUNCE_SWITCH -- requirements
Module: debounce_switch

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000, number of consecutive sampled cycles a new level must persist before acceptance (10 ms at 25 MHz); legal range 2..2^24-1.
REQ-002 SHALL have port i_Clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port i_Switch  input  1  raw, asynchronous, bouncing switch level.
REQ-005 SHALL have port o_Switch  output  1  debounced level, registered.
REQ-006 SHALL have, only when DEBOUNCE_EDGE_EN is defined, port o_Rise  output  1  one-cycle pulse on accepted 0->1.
REQ-007 SHALL have, only when DEBOUNCE_EDGE_EN is defined, port o_Fall  output  1  one-cycle pulse on accepted 1->0.

Function
REQ-008 SHALL pass i_Switch through a two-flop synchronizer; only the second flop's output (sync) feeds the filter.
REQ-009 SHALL hold an internal counter sized ceil(log2(DEBOUNCE_LIMIT)) bits; no wrap-around possible.
REQ-010 SHALL, each edge where sync equals o_Switch, clear the counter and hold o_Switch.
REQ-011 SHALL, each edge where sync differs from o_Switch and counter < DEBOUNCE_LIMIT-1, increment counter by 1.
REQ-012 SHALL, on the edge where sync differs and counter == DEBOUNCE_LIMIT-1, load o_Switch with sync and clear counter in the same edge.
REQ-013 SHALL therefore accept a change after exactly DEBOUNCE_LIMIT consecutive differing sync samples; latency from a stable i_Switch change to o_Switch = DEBOUNCE_LIMIT+2 rising edges.
REQ-014 SHALL reject any pulse/glitch shorter than DEBOUNCE_LIMIT sync cycles; a single matching sample restarts the count from 0.
REQ-015 SHALL treat rising and falling transitions identically (symmetric filter).
REQ-016 SHALL change o_Switch at most once per DEBOUNCE_LIMIT cycles; o_Switch never glitches combinationally.

Reset
REQ-017 SHALL, while i_reset is high, asynchronously force both synchronizer flops, counter, o_Switch (and o_Rise, o_Fall) to 0, regardless of i_Clk.
REQ-018 SHALL resume filtering on the first rising edge after i_reset falls; a switch held high through reset is reported high DEBOUNCE_LIMIT+2 edges after release.
REQ-019 SHALL discard any in-progress count when reset is asserted mid-count; no partial count survives.

Configuration
REQ-020 SHALL, when macro DEBOUNCE_EDGE_EN is defined, generate o_Rise/o_Fall registered, asserted high for exactly one cycle, in the same cycle o_Switch takes its new value (o_Rise when new value 1, o_Fall when 0).
REQ-021 SHALL, when DEBOUNCE_EDGE_EN is undefined, omit o_Rise/o_Fall ports and their logic entirely; o_Switch behaviour is identical in both builds.

Verification (DEBOUNCE_LIMIT=4 unless noted)
REQ-022 SHALL cover: reset asserted, i_Switch=1 -> o_Switch=0 immediately (asynchronous), stays 0 while reset high.
REQ-023 SHALL cover: release reset, i_Switch steps 0->1 and holds -> o_Switch rises on exactly the 6th rising edge after the step; o_Rise=1 that cycle only (edge build).
REQ-024 SHALL cover: o_Switch=1, i_Switch low for 3 cycles then high -> o_Switch stays 1, counter back to 0.
REQ-025 SHALL cover: bounce pattern 1,0,1,1,0,1,1,1,1 (one sample/cycle) -> o_Switch rises only after the final 4 consecutive 1s plus 2 sync cycles.
REQ-026 SHALL cover: i_Switch 1->0 held -> o_Switch falls 6 edges later, o_Fall one-cycle pulse; no o_Rise.
REQ-027 SHALL cover: i_reset pulsed when counter=3 -> o_Switch=0, counter 0; subsequent change needs full 6 edges.
